// File: rtl/eq_check_ctrl.sv
// Run controller for an equivalence check: drives LFSR stimulus, collects per-output
// equality results. Define EQ_CHECK_STOP_ON_FAIL_EN to end a run right after its first mismatch.
module eq_check_ctrl #(
  parameter int IN_W   = 6,
  parameter int OUT_W  = 3,
  parameter int WARMUP = 4,
  parameter int NCYC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       seed,
  input  logic [NCYC_W-1:0] num_cycles,
  output logic [IN_W-1:0]   stim,
  input  logic [OUT_W-1:0]  eq_vec,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [OUT_W-1:0]  fail_mask,
  output logic [NCYC_W-1:0] fail_cycle,
  output logic [NCYC_W-1:0] cycle_cnt
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [7:0]  WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_arm;
  logic [31:0]       r_lfsr;
  logic [IN_W-1:0]   r_stim;
  logic [7:0]        r_warm_cnt;
  logic [NCYC_W-1:0] r_num;
  logic [NCYC_W-1:0] r_cnt;
  logic [NCYC_W-1:0] r_fail_cycle;
  logic [OUT_W-1:0]  r_fail_mask;
  logic              r_fail;

  logic              w_start_ok;
  logic              w_advance;
  logic              w_warm_last;
  logic              w_stop;
  logic              w_run_end;
  logic              w_check;
  logic              w_mism;
  logic [31:0]       w_seed_eff;
  logic [31:0]       w_lfsr_step;
  logic [31:0]       w_lfsr_next;

`ifdef EQ_CHECK_STOP_ON_FAIL_EN
  assign w_stop = r_fail;
`else
  assign w_stop = 1'b0;
`endif

  // r_arm holds off start for one edge after reset release so the release stays synchronous.
  assign w_start_ok  = start && r_arm && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_advance   = (r_state == S_WARM) || (r_state == S_RUN);
  assign w_warm_last = (r_warm_cnt == WARM_LAST);
  assign w_run_end   = (r_cnt >= r_num) || w_stop;
  assign w_check     = (r_state == S_RUN) && !w_run_end;
  assign w_mism      = w_check && (|(~eq_vec));
  assign w_seed_eff  = (seed == 32'd0) ? 32'd1 : seed;
  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);
  assign w_lfsr_next = w_start_ok ? w_seed_eff : (w_advance ? w_lfsr_step : r_lfsr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) w_state_next = (WARMUP == 0) ? S_RUN : S_WARM;
      end
      S_WARM: begin
        if (w_warm_last) w_state_next = (r_num == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_run_end) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm        <= 1'b0;
      r_lfsr       <= 32'd1;
      r_stim       <= '0;
      r_warm_cnt   <= '0;
      r_num        <= '0;
      r_cnt        <= '0;
      r_fail_cycle <= '0;
      r_fail_mask  <= '0;
      r_fail       <= 1'b0;
    end else begin
      r_arm  <= 1'b1;
      r_lfsr <= w_lfsr_next;
      if (w_start_ok || w_advance) r_stim <= w_lfsr_next[IN_W-1:0];
      if (w_start_ok) begin
        r_warm_cnt   <= '0;
        r_num        <= num_cycles;
        r_cnt        <= '0;
        r_fail_cycle <= '0;
        r_fail_mask  <= '0;
        r_fail       <= 1'b0;
      end else begin
        if (r_state == S_WARM) r_warm_cnt <= r_warm_cnt + 8'd1;
        if (w_check) begin
          r_cnt       <= (r_cnt == '1) ? r_cnt : r_cnt + NCYC_W'(1);
          r_fail_mask <= r_fail_mask | ~eq_vec;
          // Index recorded is the count before this cycle's increment.
          if (w_mism && !r_fail) begin
            r_fail       <= 1'b1;
            r_fail_cycle <= r_cnt;
          end
        end
      end
    end
  end

  assign stim       = r_stim;
  assign busy       = w_advance;
  assign done       = (r_state == S_DONE);
  assign fail       = r_fail;
  assign fail_mask  = r_fail_mask;
  assign fail_cycle = r_fail_cycle;
  assign cycle_cnt  = r_cnt;

endmodule

// File: tb/tb_eq_check_ctrl.sv
// Randomized bench for eq_check_ctrl: a run-level model predicts stimulus trace,
// latency and results from the seed and a per-checked-cycle mismatch plan.
module tb_eq_check_ctrl;
  localparam int IN_W   = 6;
  localparam int OUT_W  = 3;
  localparam int WARMUP = 4;
  localparam int NCYC_W = 16;
  localparam int MAXN   = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       seed = '0;
  logic [NCYC_W-1:0] num_cycles = '0;
  logic [IN_W-1:0]   stim;
  logic [OUT_W-1:0]  eq_vec = '1;
  logic              busy, done, fail;
  logic [OUT_W-1:0]  fail_mask;
  logic [NCYC_W-1:0] fail_cycle, cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OUT_W-1:0] plan [MAXN];
`ifdef EQ_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP_MODE = 1'b1;
`else
  localparam bit STOP_MODE = 1'b0;
`endif

  always #5 clk = ~clk;

  eq_check_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .WARMUP(WARMUP), .NCYC_W(NCYC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_cycles(num_cycles),
    .stim(stim), .eq_vec(eq_vec), .busy(busy), .done(done), .fail(fail),
    .fail_mask(fail_mask), .fail_cycle(fail_cycle), .cycle_cnt(cycle_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < MAXN; i++) plan[i] = '0;
  endtask

  task automatic random_plan(input int n);
    logic [OUT_W-1:0] m;
    clear_plan();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        m = OUT_W'($urandom);
        plan[i] = (m == '0) ? OUT_W'(1) : m;
      end
    end
  endtask

  // One run from start to DONE; ign_c >= 0 pulses a conflicting start in busy cycle ign_c.
  task automatic run_case(input string tag, input logic [31:0] sd, input int n,
                          input bit noise, input int ign_c);
    logic [31:0]      s;
    logic [OUT_W-1:0] emask;
    bit               efail;
    int               efc, ecnt, elat, c, lat, k;
    efail = 1'b0; emask = '0; efc = 0; ecnt = 0;
    for (int i = 0; i < n; i++) begin
      if (plan[i] != '0) begin
        if (!efail) begin efail = 1'b1; efc = i; end
        emask |= plan[i];
      end
      ecnt = i + 1;
      if (STOP_MODE && efail) break;
    end
    if (n == 0) elat = WARMUP;
    else if (STOP_MODE && efail) elat = WARMUP + efc + 2;
    else elat = WARMUP + n + 1;

    @(negedge clk);
    start = 1'b1; seed = sd; num_cycles = NCYC_W'(n); eq_vec = '1;
    @(posedge clk);
    s = (sd == 32'd0) ? 32'd1 : sd;
    c = 0; lat = -1;
    while (lat < 0) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = c;
      end else if (c > elat + 20) begin
        check_eq({tag, ".timeout"}, 32'(c), 32'(elat));
        lat = c;
      end else begin
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        check_eq({tag, ".stim"}, 32'(stim), 32'(s[IN_W-1:0]));
        if (c == ign_c) begin
          start = 1'b1; seed = ~sd; num_cycles = NCYC_W'(3);
        end
        if (c < WARMUP) begin
          eq_vec = noise ? OUT_W'($urandom) : '1;
        end else begin
          k = c - WARMUP;
          if (k < n) eq_vec = ~plan[k];
          else eq_vec = noise ? OUT_W'($urandom) : '1;
        end
        s = lfsr_step(s);
        c++;
      end
    end
    eq_vec = '1;
    check_eq({tag, ".lat"}, 32'(lat), 32'(elat));
    check_eq({tag, ".busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, ".fail"}, 32'(fail), 32'(efail));
    check_eq({tag, ".mask"}, 32'(fail_mask), 32'(emask));
    check_eq({tag, ".fcyc"}, 32'(fail_cycle), 32'(efc));
    check_eq({tag, ".cnt"}, 32'(cycle_cnt), 32'(ecnt));
    check_eq({tag, ".stim_done"}, 32'(stim), 32'(s[IN_W-1:0]));
    repeat (3) @(negedge clk);
    check_eq({tag, ".hold_done"}, 32'(done), 32'd1);
    check_eq({tag, ".hold_cnt"}, 32'(cycle_cnt), 32'(ecnt));
    check_eq({tag, ".hold_stim"}, 32'(stim), 32'(s[IN_W-1:0]));
    $display("run %s seed=0x%08h n=%0d lat=%0d fail=%0d mask=%0b fcyc=%0d cnt=%0d",
             tag, sd, n, lat, fail, fail_mask, fail_cycle, cycle_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sd;
    int          n;
    clear_plan();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.stim", 32'(stim), 32'd0);
    check_eq("rst.cnt", 32'(cycle_cnt), 32'd0);
    // A start on the first edge after release must be ignored.
    rst_n = 1'b1; start = 1'b1; seed = 32'h1234; num_cycles = NCYC_W'(10);
    @(negedge clk);
    start = 1'b0;
    check_eq("rst.early_start", 32'(busy | done), 32'd0);

    clear_plan();
    run_case("s1", 32'h0000_ACE1, 100, 1'b0, -1);

    clear_plan(); plan[37] = 3'b010;
    run_case("s2", $urandom, 100, 1'b0, -1);

    clear_plan();
    run_case("s3", $urandom, 60, 1'b1, -1);

    clear_plan();
    run_case("s4_seed0", 32'd0, 40, 1'b0, -1);
    run_case("s4_seed1", 32'd1, 40, 1'b0, -1);
    run_case("s4_again", 32'd0, 40, 1'b0, -1);

    // Reset in the middle of a run, after a mismatch has been recorded.
    clear_plan(); plan[20] = 3'b101;
    @(negedge clk);
    start = 1'b1; seed = $urandom; num_cycles = NCYC_W'(100);
    @(posedge clk);
    for (int c = 0; c < WARMUP + 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      eq_vec = (c >= WARMUP) ? ~plan[c - WARMUP] : '1;
    end
    @(negedge clk);
    eq_vec = '1;
    check_eq("s5.prefail", 32'(fail), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("s5.busy", 32'(busy), 32'd0);
    check_eq("s5.done", 32'(done), 32'd0);
    check_eq("s5.fail", 32'(fail), 32'd0);
    check_eq("s5.mask", 32'(fail_mask), 32'd0);
    check_eq("s5.fcyc", 32'(fail_cycle), 32'd0);
    check_eq("s5.cnt", 32'(cycle_cnt), 32'd0);
    check_eq("s5.stim", 32'(stim), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_plan();
    run_case("s5_after", $urandom, 30, 1'b0, -1);

    clear_plan(); plan[5] = 3'b001;
    run_case("s6_ign", $urandom, 50, 1'b0, WARMUP + 10);
    run_case("s6_zero", $urandom, 0, 1'b1, -1);

    clear_plan(); plan[0] = 3'b100; plan[9] = 3'b001;
    run_case("edge_first_last", $urandom, 10, 1'b1, -1);
    clear_plan();
    run_case("edge_n1", $urandom, 1, 1'b1, -1);

    for (int r = 0; r < 6; r++) begin
      sd = $urandom;
      n  = $urandom_range(1, 200);
      random_plan(n);
      run_case($sformatf("rnd%0d", r), sd, n, 1'(r & 1), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/eq_check_ctrl.md
EQ_CHECK_CTRL -- requirements
Module: eq_check_ctrl

Interface
REQ-001 Parameter IN_W, default 6, width of the stimulus vector driven to the equivalence top (1..32).
REQ-002 Parameter OUT_W, default 3, number of per-output equality bits returned (1..32).
REQ-003 Parameter WARMUP, default 4, cycles after start during which mismatches are ignored (0..255).
REQ-004 Parameter NCYC_W, default 16, width of the cycle-count registers.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle pulse that begins a run; ignored unless the FSM is in IDLE or DONE.
REQ-008 seed  in  32  LFSR seed, sampled on the accepted start.
REQ-009 num_cycles  in  NCYC_W  checked cycles per run, sampled on the accepted start.
REQ-010 stim  out  IN_W  registered stimulus equal to lfsr[IN_W-1:0].
REQ-011 eq_vec  in  OUT_W  per-output equality bits from the equivalence top (1 = equal), combinational from stim.
REQ-012 busy  out  1  high in WARM and RUN.
REQ-013 done  out  1  high in DONE.
REQ-014 fail  out  1  sticky mismatch flag for the current run.
REQ-015 fail_mask  out  OUT_W  OR-accumulated ~eq_vec over checked cycles.
REQ-016 fail_cycle  out  NCYC_W  checked-cycle index of the first mismatch.
REQ-017 cycle_cnt  out  NCYC_W  checked cycles completed in the current run.

Function
REQ-018 FSM states are IDLE, WARM, RUN and DONE; the encoding is free.
REQ-019 An accepted start loads lfsr <= (seed==0 ? 1 : seed), clears fail, fail_mask, fail_cycle and cycle_cnt, and enters WARM, or RUN if WARMUP==0.
REQ-020 LFSR: 32-bit Galois, taps 0x80200003; it advances once per cycle in WARM and RUN and holds in IDLE and DONE.
REQ-021 WARM lasts exactly WARMUP cycles; eq_vec is ignored during WARM.
REQ-022 In each RUN cycle, eq_vec is checked against the current stim, cycle_cnt increments, and fail_mask |= ~eq_vec.
REQ-023 First mismatch in RUN: fail is set and fail_cycle captures the cycle_cnt value before the increment; later mismatches do not change fail_cycle.
REQ-024 RUN goes to DONE in the cycle after cycle_cnt reaches num_cycles.
REQ-025 An accepted start with num_cycles==0 completes WARM, then goes directly to DONE with cycle_cnt=0.
REQ-026 cycle_cnt saturates at all-ones and does not wrap.
REQ-027 A start pulse while busy is ignored and has no effect.
REQ-028 A start pulse in DONE begins a new run, with all results cleared in the same edge.
REQ-029 done stays high and the results hold in DONE until the next accepted start.

Reset
REQ-030 rst_n low forces state IDLE, lfsr=1, stim=0, and busy, done, fail, fail_mask, fail_cycle and cycle_cnt all 0, asynchronously.
REQ-031 Reset asserted during a run aborts it; no partial result is retained.
REQ-032 Reset deassertion is synchronous: the first start is accepted no earlier than the second rising edge after rst_n rises.

Configuration
REQ-033 Macro EQ_CHECK_STOP_ON_FAIL_EN, when defined, makes RUN go to DONE in the cycle after the first mismatch; cycle_cnt then equals fail_cycle+1.
REQ-034 When EQ_CHECK_STOP_ON_FAIL_EN is undefined, the run always completes num_cycles, and fail_mask accumulates over the whole run.

Verification
REQ-035 Scenario 1: eq_vec tied all-ones, seed=0xACE1, num_cycles=100, WARMUP=4 -> done after 105 cycles from start; fail=0, fail_mask=0, cycle_cnt=100.
REQ-036 Scenario 2: eq_vec[1] forced 0 at checked cycle 37 only -> fail=1, fail_cycle=37, fail_mask=3'b010; cycle_cnt=100 without the macro, 38 with it.
REQ-037 Scenario 3: mismatch injected only during WARM -> fail=0 at done.
REQ-038 Scenario 4: seed=0 -> stim sequence identical to seed=1; a second start in DONE with the same seed reproduces the identical stim trace.
REQ-039 Scenario 5: rst_n pulsed low at checked cycle 50 -> all outputs 0 immediately, state IDLE; a start 2 cycles after release runs normally.
REQ-040 Scenario 6: start pulsed at RUN cycle 10; then num_cycles=0 -> the first pulse is ignored and the run is unchanged; num_cycles=0 gives DONE with cycle_cnt=0.
